glyph_matcher: RTL and testbench

- Consumer and reader side of the digit-glyph template ROMs in the number-recognition path.
- Steps row addresses through a captured 16x16 binary image and through each of 10 digit templates (0-9).
- Scores each template by counting agreeing pixels and reports the best-matching digit with its score.
- Sits between the image capture buffer and the display/result logic.

---
 rtl/glyph_pkg.sv | 15 +
 rtl/row_popcount16.sv | 12 +
 rtl/glyph_matcher.sv | 140 ++++++++++++++
 tb/tb_glyph_matcher.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared sizes and FSM state encoding for the digit-glyph matcher.
// The optional margin output is enabled by defining NUMRECOG_MARGIN_EN.
package glyph_pkg;
  localparam int ROWS       = 16;
  localparam int NUM_DIGITS = 10;
  localparam int SCORE_W    = 9;
  localparam int ROW_AW     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/row_popcount16.sv
// Combinational population count of one 16-bit glyph row (0..16).
module row_popcount16 (
  input  logic [15:0] bits,
  output logic [4:0]  count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + {4'd0, bits[i]};
    end
  end
endmodule

// File: rtl/glyph_matcher.sv
// Scores a 16x16 binary image against digit templates 0..9 by pixel agreement
// and reports the best digit. Define NUMRECOG_MARGIN_EN for margin/valid outputs.
module glyph_matcher
  import glyph_pkg::*;
`ifdef NUMRECOG_MARGIN_EN
#(
  parameter int MIN_MARGIN = 8
)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ROW_AW-1:0]  img_addr,
  input  logic [ROWS-1:0]    img_row,
  output logic [3:0]         tmpl_sel,
  output logic [ROW_AW-1:0]  tmpl_addr,
  input  logic [ROWS-1:0]    tmpl_row,
  output logic               busy,
  output logic               done,
  output logic [3:0]         digit,
  output logic [SCORE_W-1:0] score,
`ifdef NUMRECOG_MARGIN_EN
  output logic [SCORE_W-1:0] margin,
  output logic               valid,
`endif
  output state_t             dbg_state
);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
  localparam logic [3:0]        LAST_SEL = 4'(NUM_DIGITS - 1);

  state_t             state, state_nx;
  logic [ROW_AW-1:0]  row;
  logic [3:0]         sel;
  logic [SCORE_W-1:0] acc, best_score;
  logic [3:0]         best_digit;
  logic [3:0]         digit_q;
  logic [SCORE_W-1:0] score_q;
  logic [4:0]         agree;
  logic               new_best;
  logic [SCORE_W-1:0] cmp_best;
  logic [3:0]         cmp_digit;

  row_popcount16 u_pop (
    .bits  (~(img_row ^ tmpl_row)),
    .count (agree)
  );

  // Strict compare: on a tie the earlier (lower) digit is kept.
  assign new_best  = acc > best_score;
  assign cmp_best  = new_best ? acc : best_score;
  assign cmp_digit = new_best ? sel : best_digit;

`ifdef NUMRECOG_MARGIN_EN
  logic [SCORE_W-1:0] second_score, cmp_second, cmp_margin;
  logic [SCORE_W-1:0] margin_q;
  logic               valid_q;
  assign cmp_second = new_best ? best_score :
                      (acc > second_score) ? acc : second_score;
  assign cmp_margin = cmp_best - cmp_second;
  assign margin     = margin_q;
  assign valid      = valid_q;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = ACC;
      ACC:  if (row == LAST_ROW) state_nx = CMP;
      CMP:  state_nx = (sel == LAST_SEL) ? DONE : ACC;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      sel        <= '0;
      acc        <= '0;
      best_score <= '0;
      best_digit <= '0;
      digit_q    <= '0;
      score_q    <= '0;
`ifdef NUMRECOG_MARGIN_EN
      second_score <= '0;
      margin_q     <= '0;
      valid_q      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          row        <= '0;
          sel        <= '0;
          acc        <= '0;
          best_score <= '0;
          best_digit <= '0;
`ifdef NUMRECOG_MARGIN_EN
          second_score <= '0;
`endif
        end
        ACC: begin
          acc <= acc + SCORE_W'(agree);
          row <= row + 1'b1;
        end
        CMP: begin
          best_score <= cmp_best;
          best_digit <= cmp_digit;
          acc        <= '0;
`ifdef NUMRECOG_MARGIN_EN
          second_score <= cmp_second;
`endif
          // Results are loaded on the edge into DONE so they are visible with done.
          if (sel == LAST_SEL) begin
            digit_q <= cmp_digit;
            score_q <= cmp_best;
`ifdef NUMRECOG_MARGIN_EN
            margin_q <= cmp_margin;
            valid_q  <= cmp_margin >= SCORE_W'(MIN_MARGIN);
`endif
          end else begin
            sel <= sel + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign img_addr  = row;
  assign tmpl_addr = row;
  assign tmpl_sel  = sel;
  assign busy      = (state == ACC) || (state == CMP);
  assign done      = (state == DONE);
  assign digit     = digit_q;
  assign score     = score_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_glyph_matcher.sv
// Directed bench for glyph_matcher: scan-timeline model plus literal results.
module tb_glyph_matcher;
  import glyph_pkg::*;

  // Handshake: start is a single-cycle request sampled on posedge while idle;
  // done is a single-cycle pulse and digit/score are valid from that cycle on.

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  img_addr, tmpl_sel, tmpl_addr, digit;
  logic [15:0] img_row, tmpl_row;
  logic        busy, done;
  logic [8:0]  score;
`ifdef NUMRECOG_MARGIN_EN
  logic [8:0]  margin;
  logic        valid;
`endif
  state_t      dbg_state;

  logic [15:0] img_mem [16];
  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  int cnt = 0;
  int exp_digit = 0, exp_score = 0, exp_margin = 0, exp_valid = 0;

  always #5 clk = ~clk;

  assign img_row  = img_mem[img_addr];
  assign tmpl_row = 16'h0001 << tmpl_sel;

  glyph_matcher dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_addr(img_addr), .img_row(img_row),
    .tmpl_sel(tmpl_sel), .tmpl_addr(tmpl_addr), .tmpl_row(tmpl_row),
    .busy(busy), .done(done), .digit(digit), .score(score),
`ifdef NUMRECOG_MARGIN_EN
    .margin(margin), .valid(valid),
`endif
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Whole-scan reference: score each template, strict-greater best and runner-up.
  function automatic void model_scan(output int d, output int s, output int sec);
    int sc;
    logic [15:0] t;
    d = 0; s = 0; sec = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sc = 0;
      t = 16'h0001 << k;
      for (int r = 0; r < ROWS; r++) sc += $countones(~(img_mem[r] ^ t));
      if (sc > s) begin sec = s; s = sc; d = k; end
      else if (sc > sec) sec = sc;
    end
  endfunction

  // Timeline model: cnt is the cycle index within a scan (0 = idle, 171 = done).
  always @(posedge clk) begin : model_proc
    int d, s, sec;
    if (!rst_n) begin
      cnt <= 0; exp_digit <= 0; exp_score <= 0; exp_margin <= 0; exp_valid <= 0;
    end else if (cnt == 0) begin
      if (start) cnt <= 1;
    end else if (cnt == 170) begin
      model_scan(d, s, sec);
      cnt <= 171;
      exp_digit <= d; exp_score <= s;
      exp_margin <= s - sec; exp_valid <= ((s - sec) >= 8) ? 1 : 0;
    end else if (cnt == 171) begin
      cnt <= 0;
    end else begin
      cnt <= cnt + 1;
    end
  end

  always @(negedge clk) begin : cmp_proc
    int er, st;
    bit running;
    if (chk_en) begin
      running = (cnt >= 1) && (cnt <= 170);
      er = (running && ((cnt - 1) % 17) < 16) ? (cnt - 1) % 17 : 0;
      check("img_addr", img_addr, er);
      check("tmpl_addr", tmpl_addr, er);
      if (cnt >= 1) check("tmpl_sel", tmpl_sel, (cnt == 171) ? 9 : (cnt - 1) / 17);
      check("busy", busy, running);
      check("done", done, cnt == 171);
      check("digit", digit, exp_digit);
      check("score", score, exp_score);
`ifdef NUMRECOG_MARGIN_EN
      check("margin", margin, exp_margin);
      check("valid", valid, exp_valid);
`endif
      st = (cnt == 0) ? 0 : (cnt == 171) ? 3 : (((cnt - 1) % 17) == 16) ? 2 : 1;
      check("state", dbg_state, st);
    end
  end

  task automatic fill_img(input logic [15:0] lo, input logic [15:0] hi);
    for (int r = 0; r < 16; r++) img_mem[r] = (r < 8) ? lo : hi;
  endtask

  // Starts a scan, optionally re-pulses start at cycles 5/100 or resets at cycle 60,
  // then watches 180 cycles for done pulses.
  task automatic run_scan(input string tag, input int exp_d, input int exp_s,
                          input int exp_m, input bit inject, input bit do_rst);
    int d, s, sec, n_done, first_done;
    model_scan(d, s, sec);
    if (!do_rst) begin
      check({tag, "_model_digit"}, d, exp_d);
      check({tag, "_model_score"}, s, exp_s);
      check({tag, "_model_margin"}, s - sec, exp_m);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_done = 0; first_done = 0;
    for (int c = 1; c <= 180; c++) begin
      @(negedge clk);
      if (done) begin n_done++; if (first_done == 0) first_done = c; end
      if (do_rst && c == 61) begin
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_digit"}, digit, 0);
        check({tag, "_rst_score"}, score, 0);
      end
      start = inject && (c == 5 || c == 100);
      rst_n = !(do_rst && c == 60);
    end
    start = 1'b0; rst_n = 1'b1;
    if (do_rst) begin
      check({tag, "_done_count"}, n_done, 0);
      check({tag, "_digit"}, digit, 0);
      check({tag, "_score"}, score, 0);
    end else begin
      check({tag, "_done_count"}, n_done, 1);
      check({tag, "_latency"}, first_done, 171);
      check({tag, "_digit"}, digit, exp_d);
      check({tag, "_score"}, score, exp_s);
`ifdef NUMRECOG_MARGIN_EN
      check({tag, "_margin"}, margin, exp_m);
      check({tag, "_valid"}, valid, (exp_m >= 8) ? 1 : 0);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    fill_img(16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_digit", digit, 0);
    check("reset_score", score, 0);
    check("reset_img_addr", img_addr, 0);
    check("reset_tmpl_sel", tmpl_sel, 0);

    // Template k rows are 1<<k; 0x0010 matches digit 4 exactly, others agree on 14 bits.
    fill_img(16'h0010, 16'h0010);
    run_scan("single_bit", 4, 256, 32, 1'b0, 1'b0);
    // All ones agree with every template on exactly one bit per row: tie, digit 0.
    fill_img(16'hFFFF, 16'hFFFF);
    run_scan("all_ones", 0, 16, 0, 1'b0, 1'b0);
    // Digits 2 and 6 both score 8*16 + 8*14 = 240; the lower digit wins.
    fill_img(16'h0004, 16'h0040);
    run_scan("split_tie", 2, 240, 0, 1'b0, 1'b0);
    fill_img(16'h0010, 16'h0010);
    run_scan("ignored_start", 4, 256, 32, 1'b1, 1'b0);
    fill_img(16'h0100, 16'h0100);
    run_scan("abort", 0, 0, 0, 1'b0, 1'b1);
    run_scan("after_abort", 8, 256, 32, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
